// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl -- sequential unsigned shift-add multiplier with controller.
//
// A start request in IDLE latches the operands. The multiplier then spends
// WIDTH cycles in CALC, one accumulator step per cycle. The final accumulator
// value is copied to the product register, and the block spends one cycle in
// DONE before it returns to IDLE.
//
// If either operand is zero, the block skips CALC, loads product = 0 and moves
// straight to DONE.
//
// Ports
//   clk      : clock, rising edge active
//   rst_n    : asynchronous active-low reset
//   start    : multiply request, sampled only in IDLE
//   a        : multiplicand (unsigned, WIDTH bits)
//   b        : multiplier   (unsigned, WIDTH bits)
//   busy     : high in CALC and DONE
//   done     : one-cycle pulse in DONE
//   product  : registered result a*b (2*WIDTH bits), held until next start
//
// Also contains full_adder, the 1-bit cell of the ripple-carry adder.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// full_adder -- single-bit full adder.
//   a_i, b_i, cin_i : addend bits and carry in
//   sum_o, cout_o   : sum bit and carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

module seq_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // The counter must be able to hold WIDTH, which it reaches on the last step.
   localparam int                CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      mcand_q, mcand_d;
   logic [2*WIDTH-1:0]    acc_q,   acc_d;
   logic [2*WIDTH-1:0]    prod_q,  prod_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;

   logic [WIDTH-1:0]      acc_hi;
   logic [WIDTH-1:0]      add_sum;
   logic [WIDTH:0]        carry;
   logic                  add_cout;
   logic [WIDTH:0]        step_upper;
   logic [2*WIDTH-1:0]    acc_step;
   logic                  zero_op;

   // ---------------------------------------------------------------------------
   // Ripple-carry adder: acc_hi + multiplicand.
   // ---------------------------------------------------------------------------
   assign acc_hi   = acc_q[2*WIDTH-1:WIDTH];
   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rca
      full_adder u_fa (
         .a_i    (acc_hi[i]),
         .b_i    (mcand_q[i]),
         .cin_i  (carry[i]),
         .sum_o  (add_sum[i]),
         .cout_o (carry[i+1])
      );
   end

   assign add_cout = carry[WIDTH];

   // ---------------------------------------------------------------------------
   // One shift-add step.
   //
   // The low half of the accumulator holds the not-yet-consumed multiplier
   // bits, so bit 0 decides whether to add. The adder carry becomes the new
   // MSB after the right shift, which is why the upper part is WIDTH+1 bits.
   // ---------------------------------------------------------------------------
   always_comb begin
      step_upper = {1'b0, acc_hi};
      if (acc_q[0]) begin
         step_upper = {add_cout, add_sum};
      end
      acc_step = {step_upper, acc_q[WIDTH-1:1]};
   end

   assign zero_op = (a == '0) || (b == '0);

   // ---------------------------------------------------------------------------
   // State and datapath registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath control.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (zero_op) begin
                  prod_d  = '0;
                  state_d = DONE;
               end else begin
                  mcand_d = a;
                  acc_d   = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end

         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            // product is updated only with the complete result, never mid-way.
            if (cnt_q == LAST_STEP) begin
               prod_d  = acc_step;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode directly from the state register, so they change only on
   // clock edges or on asynchronous reset.
   assign busy    = (state_q == CALC) || (state_q == DONE);
   assign done    = (state_q == DONE);
   assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

   logic        clk;
   logic        rst_n;

   logic        start4,  start8,  start16;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        busy4, busy8, busy16;
   logic        done4, done8, done16;
   logic [7:0]  prod4;
   logic [15:0] prod8;
   logic [31:0] prod16;

   int n_vec;
   int n_err;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          busy_cyc;
   } vec_t;

   vec_t tbl[12];

   seq_mult_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(prod4)
   );

   seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   seq_mult_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(prod16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic busy_of(input int w);
      case (w)
         4:       return busy4;
         8:       return busy8;
         default: return busy16;
      endcase
   endfunction

   function automatic logic done_of(input int w);
      case (w)
         4:       return done4;
         8:       return done8;
         default: return done16;
      endcase
   endfunction

   function automatic logic [31:0] prod_of(input int w);
      case (w)
         4:       return {24'b0, prod4};
         8:       return {16'b0, prod8};
         default: return prod16;
      endcase
   endfunction

   task automatic drive(input int w, input logic s, input logic [15:0] x, input logic [15:0] y);
      case (w)
         4: begin
            start4 = s; a4 = x[3:0]; b4 = y[3:0];
         end
         8: begin
            start8 = s; a8 = x[7:0]; b8 = y[7:0];
         end
         default: begin
            start16 = s; a16 = x; b16 = y;
         end
      endcase
   endtask

   // One complete operation. Operands are inverted right after acceptance, so
   // any sensitivity to them while busy shows up as a wrong product.
   task automatic op(input int w, input logic [15:0] ta, input logic [15:0] tb,
                     input logic [31:0] exp, input int exp_busy, input string nm);
      int          nb;
      int          nd;
      int          dpos;
      logic        partial;
      logic [31:0] prev;
      @(negedge clk);
      prev = prod_of(w);
      drive(w, 1'b1, ta, tb);
      @(negedge clk);
      drive(w, 1'b0, ~ta, ~tb);
      nb = 0; nd = 0; dpos = 0; partial = 1'b0;
      for (int c = 0; c < w + 8; c++) begin
         if (!busy_of(w)) break;
         nb++;
         if (done_of(w)) begin
            nd++;
            dpos = nb;
         end else if (prod_of(w) !== prev) begin
            partial = 1'b1;
         end
         @(negedge clk);
      end
      chk({nm, " busy cycles"}, 32'(nb), 32'(exp_busy));
      chk({nm, " done count"},  32'(nd), 32'd1);
      chk({nm, " done cycle"},  32'(dpos), 32'(exp_busy));
      chk({nm, " partial product"}, 32'(partial), 32'd0);
      chk({nm, " product"}, prod_of(w), exp);
   endtask

   task automatic wait_done8(output int n);
      n = 0;
      while (done8 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic rand_regress(input int w);
      logic [15:0] ta;
      logic [15:0] tb;
      logic [15:0] mask;
      logic [31:0] e;
      mask = 16'((32'd1 << w) - 1);
      for (int i = 0; i < 1000; i++) begin
         if (w == 4 && i < 256) begin
            ta = 16'(i[7:4]);
            tb = 16'(i[3:0]);
         end else begin
            ta = 16'($urandom) & mask;
            tb = 16'($urandom) & mask;
            if (i % 40 == 0) ta = '0;
            if (i % 40 == 1) tb = '0;
            if (i % 40 == 2) begin
               ta = mask;
               tb = mask;
            end
         end
         e = 32'(ta) * 32'(tb);
         op(w, ta, tb, e, (ta == 0 || tb == 0) ? 1 : w + 1, "rand");
      end
   endtask

   initial begin
      int          n;
      logic        seen;

      n_vec = 0;
      n_err = 0;

      tbl[0]  = '{8'h03, 8'h05, 16'h000F, 9};
      tbl[1]  = '{8'hFF, 8'hFF, 16'hFE01, 9};
      tbl[2]  = '{8'h00, 8'h7A, 16'h0000, 1};
      tbl[3]  = '{8'h7A, 8'h00, 16'h0000, 1};
      tbl[4]  = '{8'h01, 8'h01, 16'h0001, 9};
      tbl[5]  = '{8'h80, 8'h80, 16'h4000, 9};
      tbl[6]  = '{8'h12, 8'h34, 16'h03A8, 9};
      tbl[7]  = '{8'hFF, 8'h01, 16'h00FF, 9};
      tbl[8]  = '{8'h01, 8'hFF, 16'h00FF, 9};
      tbl[9]  = '{8'hAA, 8'h55, 16'h3872, 9};
      tbl[10] = '{8'h0F, 8'h10, 16'h00F0, 9};
      tbl[11] = '{8'hC8, 8'h64, 16'h4E20, 9};

      rst_n = 1'b0;
      drive(4, 1'b0, 16'h0, 16'h0);
      drive(8, 1'b0, 16'h0, 16'h0);
      drive(16, 1'b0, 16'h0, 16'h0);

      // Reset state, with start requested while reset is held.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
      @(negedge clk);
      @(negedge clk);
      chk("reset busy",    32'(busy8), 32'd0);
      chk("reset done",    32'(done8), 32'd0);
      chk("reset product", prod_of(8), 32'd0);
      chk("reset product w16", prod_of(16), 32'd0);
      start8 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset busy", 32'(busy8), 32'd0);

      for (int i = 0; i < 12; i++) begin
         op(8, 16'(tbl[i].a), 16'(tbl[i].b), 32'(tbl[i].p), tbl[i].busy_cyc, "tbl");
      end

      // start held high for the whole operation; operands change mid-CALC.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
      @(negedge clk);
      a8 = 8'h07; b8 = 8'h09;
      wait_done8(n);
      chk("held start latency", 32'(n), 32'd8);
      chk("held start product", prod_of(8), 32'h0000_000F);
      @(negedge clk);
      chk("idle after done busy", 32'(busy8), 32'd0);
      chk("idle after done done", 32'(done8), 32'd0);
      @(negedge clk);
      chk("back-to-back accepted", 32'(busy8), 32'd1);
      start8 = 1'b0;
      wait_done8(n);
      chk("back-to-back latency", 32'(n), 32'd8);
      chk("back-to-back product", prod_of(8), 32'h0000_003F);
      @(negedge clk);

      // Reset in the middle of CALC.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid-calc busy before reset", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy",    32'(busy8), 32'd0);
      chk("abort done",    32'(done8), 32'd0);
      chk("abort product", prod_of(8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      chk("abort no done pulse", 32'(seen), 32'd0);
      op(8, 16'h0012, 16'h0034, 32'h0000_03A8, 9, "restart");

      // Reset while in DONE.
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h05; b8 = 8'h06;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(n);
      chk("done-reset latency", 32'(n), 32'd8);
      rst_n = 1'b0;
      #1;
      chk("done-reset done",    32'(done8), 32'd0);
      chk("done-reset product", prod_of(8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op(8, 16'h0005, 16'h0006, 32'h0000_001E, 9, "after done-reset");

      rand_regress(4);
      rand_regress(8);
      rand_regress(16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
